// File: rtl/sys_bridge_n.sv
// sys_bridge_n: CPU-to-peripheral bridge. Decodes a word-addressed I/O window
// into NUM_DEV device slots plus one local register slot, returns registered
// read data with a ready pulse, flags out-of-window accesses and aggregates
// device interrupts into HWInt through a pending/mask block.
module sys_bridge_n #(
    parameter int                 NUM_DEV   = 2,
    parameter logic [31:0]        BASE      = 32'h0000_7F00,
    parameter int                 SPAN_LOG2 = 4,
    parameter logic [NUM_DEV-1:0] IRQ_LEVEL = {NUM_DEV{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             PrAddr,
    input  logic [31:0]             PrWD,
    input  logic [3:0]              PrBE,
    input  logic                    PrWe,
    input  logic                    PrRe,
    output logic [31:0]             PrRD,
    output logic                    PrReady,
    output logic                    PrErr,
    output logic [SPAN_LOG2-3:0]    DEV_Addr,
    output logic [31:0]             DEV_WD,
    output logic [3:0]              DEV_BE,
    output logic [NUM_DEV-1:0]      DEV_We,
    output logic [NUM_DEV-1:0]      DEV_Re,
    input  logic [32*NUM_DEV-1:0]   DEV_RD,
    input  logic [NUM_DEV-1:0]      DEV_IRQ,
    output logic [5:0]              HWInt
);

    localparam int              AW         = SPAN_LOG2 - 2;
    localparam logic [31:0]     LP_NUM_DEV = 32'(NUM_DEV);
    localparam logic [AW-1:0]   LP_W_MASK  = AW'(0);
    localparam logic [AW-1:0]   LP_W_PEND  = AW'(1);
    localparam logic [AW-1:0]   LP_W_EADDR = AW'(2);
    localparam logic [AW-1:0]   LP_W_ECNT  = AW'(3);

    logic [31:0]        r_prrd;
    logic               r_prready;
    logic               r_prerr;
    logic [31:0]        r_err_addr;
    logic [7:0]         r_err_cnt;
    logic [NUM_DEV-1:0] r_irq_q;
    logic [NUM_DEV-1:0] r_pend;
    logic [NUM_DEV-1:0] r_mask;
    logic [5:0]         r_hwint;

    logic [31:0]        w_off;
    logic [31:0]        w_slot;
    logic               w_in_window;
    logic               w_local;
    logic               w_err;
    logic               w_lwr;
    logic               w_mask_we;
    logic               w_cnt_clr;
    logic [NUM_DEV-1:0] w_pend_w1c;
    logic [NUM_DEV-1:0] w_rise;
    logic [NUM_DEV-1:0] w_pend_next;
    logic [5:0]         w_hwint_next;
    logic [31:0]        w_rd_sel;
    logic [7:0]         w_cnt_next;

    // Window decode: addresses below BASE wrap to a huge slot and fall out.
    assign w_off       = PrAddr - BASE;
    assign w_slot      = w_off >> SPAN_LOG2;
    assign w_in_window = (PrAddr >= BASE) && (w_slot <= LP_NUM_DEV);
    assign w_local     = w_in_window && (w_slot == LP_NUM_DEV);
    assign w_err       = (PrWe | PrRe) & ~w_in_window;

    assign DEV_Addr = PrAddr[SPAN_LOG2-1:2];
    assign DEV_WD   = PrWD;
    assign DEV_BE   = PrBE;

    // Local register write decode; mask and pending bits live in byte lane 0.
    assign w_lwr      = PrWe & w_local;
    assign w_mask_we  = w_lwr & (DEV_Addr == LP_W_MASK) & PrBE[0];
    assign w_cnt_clr  = w_lwr & (DEV_Addr == LP_W_ECNT);
    assign w_pend_w1c = (w_lwr && (DEV_Addr == LP_W_PEND) && PrBE[0]) ? PrWD[NUM_DEV-1:0] : '0;
    assign w_rise     = DEV_IRQ & ~r_irq_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            assign DEV_We[gi] = PrWe & w_in_window & (w_slot == 32'(gi)) & (|PrBE);
            assign DEV_Re[gi] = PrRe & w_in_window & (w_slot == 32'(gi));
            if (IRQ_LEVEL[gi]) begin : g_level
                // Level bits track the line; W1C is ignored.
                assign w_pend_next[gi] = DEV_IRQ[gi];
            end else begin : g_edge
                // A new rising edge beats a coincident W1C.
                assign w_pend_next[gi] = (r_pend[gi] & ~w_pend_w1c[gi]) | w_rise[gi];
            end
        end
        for (gi = 0; gi < 6; gi++) begin : g_hw
            if (gi < NUM_DEV) begin : g_used
                assign w_hwint_next[gi] = r_pend[gi] & r_mask[gi];
            end else begin : g_unused
                assign w_hwint_next[gi] = 1'b0;
            end
        end
    endgenerate

    // Read source select: device word, local register, or zero.
    always_comb begin
        w_rd_sel = '0;
        if (w_local) begin
            case (DEV_Addr)
                LP_W_MASK:  w_rd_sel = 32'(r_mask);
                LP_W_PEND:  w_rd_sel = 32'(r_pend);
                LP_W_EADDR: w_rd_sel = r_err_addr;
                LP_W_ECNT:  w_rd_sel = 32'(r_err_cnt);
                default:    w_rd_sel = '0;
            endcase
        end else if (w_in_window) begin
            for (int i = 0; i < NUM_DEV; i++) begin
                if (w_slot == 32'(i)) w_rd_sel = DEV_RD[32*i +: 32];
            end
        end
    end

    // Error count: saturating increment; an error coinciding with a clear yields 1.
    always_comb begin
        w_cnt_next = r_err_cnt;
        if (w_err) begin
            if (w_cnt_clr)                w_cnt_next = 8'd1;
            else if (r_err_cnt != 8'hFF)  w_cnt_next = r_err_cnt + 8'd1;
        end else if (w_cnt_clr) begin
            w_cnt_next = 8'd0;
        end
    end

    // Read path: capture selected data and raise ready for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prrd    <= '0;
            r_prready <= 1'b0;
        end else begin
            r_prready <= PrRe;
            if (PrRe) r_prrd <= w_rd_sel;
        end
    end

    // Error tracking: pulse, faulting address and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prerr    <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_prerr   <= w_err;
            r_err_cnt <= w_cnt_next;
            if (w_err) r_err_addr <= PrAddr;
        end
    end

    // Interrupt block: line sampling, pending, mask and registered HWInt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_hwint <= '0;
        end else begin
            r_irq_q <= DEV_IRQ;
            r_pend  <= w_pend_next;
            r_hwint <= w_hwint_next;
            if (w_mask_we) r_mask <= PrWD[NUM_DEV-1:0];
        end
    end

    assign PrRD    = r_prrd;
    assign PrReady = r_prready;
    assign PrErr   = r_prerr;
    assign HWInt   = r_hwint;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed testbench for sys_bridge_n with default window, device 0 in
// level mode and device 1 in edge mode.
module tb_sys_bridge_n;

    logic        clk;
    logic        reset;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [3:0]  PrBE;
    logic        PrWe;
    logic        PrRe;
    logic [31:0] PrRD;
    logic        PrReady;
    logic        PrErr;
    logic [1:0]  DEV_Addr;
    logic [31:0] DEV_WD;
    logic [3:0]  DEV_BE;
    logic [1:0]  DEV_We;
    logic [1:0]  DEV_Re;
    logic [63:0] DEV_RD;
    logic [1:0]  DEV_IRQ;
    logic [5:0]  HWInt;

    int total = 0;
    int bad   = 0;

    sys_bridge_n #(
        .NUM_DEV   (2),
        .BASE      (32'h0000_7F00),
        .SPAN_LOG2 (4),
        .IRQ_LEVEL (2'b01)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PrAddr   (PrAddr),
        .PrWD     (PrWD),
        .PrBE     (PrBE),
        .PrWe     (PrWe),
        .PrRe     (PrRe),
        .PrRD     (PrRD),
        .PrReady  (PrReady),
        .PrErr    (PrErr),
        .DEV_Addr (DEV_Addr),
        .DEV_WD   (DEV_WD),
        .DEV_BE   (DEV_BE),
        .DEV_We   (DEV_We),
        .DEV_Re   (DEV_Re),
        .DEV_RD   (DEV_RD),
        .DEV_IRQ  (DEV_IRQ),
        .HWInt    (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PrWe = 1'b0;
        PrRe = 1'b0;
        PrBE = 4'h0;
        PrWD = 32'h0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic rdy);
        PrAddr = addr;
        PrRe   = 1'b1;
        tick();
        d   = PrRD;
        rdy = PrReady;
        PrRe = 1'b0;
        $display("rd   addr=%h data=%h ready=%b err=%b", addr, d, rdy, PrErr);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                            output logic er);
        PrAddr = addr;
        PrWD   = wd;
        PrBE   = be;
        PrWe   = 1'b1;
        tick();
        er = PrErr;
        idle();
        $display("wr   addr=%h data=%h be=%h err=%b", addr, wd, be, er);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        r;
        reset = 1'b1;
        idle();
        PrAddr  = 32'h0;
        DEV_RD  = 64'h0;
        DEV_IRQ = 2'b00;
        tick();
        tick();
        total++; if (PrRD !== 32'h0)  begin bad++; $display("FAIL rst_prrd got=%h exp=%h", PrRD, 32'h0); end
        total++; if (PrReady !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", PrReady); end
        total++; if (PrErr !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b exp=0", PrErr); end
        total++; if (HWInt !== 6'h0)   begin bad++; $display("FAIL rst_hwint got=%b exp=0", HWInt); end
        reset = 1'b0;
        tick();
        do_read(32'h7F2C, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_errcnt got=%h exp=0", d); end
    endtask

    task automatic test_dev_write();
        logic er;
        PrAddr = 32'h7F14; PrWD = 32'hDEADBEEF; PrBE = 4'hF; PrWe = 1'b1;
        #1;
        total++; if (DEV_We !== 2'b10) begin bad++; $display("FAIL wr_we got=%b exp=10", DEV_We); end
        total++; if (DEV_Addr !== 2'b01) begin bad++; $display("FAIL wr_addr got=%b exp=01", DEV_Addr); end
        total++; if (DEV_WD !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wd got=%h exp=deadbeef", DEV_WD); end
        total++; if (DEV_Re !== 2'b00) begin bad++; $display("FAIL wr_re got=%b exp=00", DEV_Re); end
        tick();
        idle();
        $display("wr   addr=00007f14 data=deadbeef be=f err=%b", PrErr);
        total++; if (PrErr !== 1'b0) begin bad++; $display("FAIL wr_noerr got=%b exp=0", PrErr); end
        // All byte enables off: no write strobe.
        PrAddr = 32'h7F04; PrWD = 32'h1; PrBE = 4'h0; PrWe = 1'b1;
        #1;
        total++; if (DEV_We !== 2'b00) begin bad++; $display("FAIL wr_be0 got=%b exp=00", DEV_We); end
        tick();
        idle();
        do_write(32'h7F0C, 32'h5, 4'h1, er);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_dev0_err got=%b exp=0", er); end
    endtask

    task automatic test_read();
        DEV_RD = {32'hCAFEF00D, 32'h12345678};
        PrAddr = 32'h7F08; PrRe = 1'b1;
        #1;
        total++; if (DEV_Re !== 2'b01) begin bad++; $display("FAIL rd_re got=%b exp=01", DEV_Re); end
        tick();
        PrRe = 1'b0;
        $display("rd   addr=00007f08 data=%h ready=%b", PrRD, PrReady);
        total++; if (PrRD !== 32'h12345678) begin bad++; $display("FAIL rd_data got=%h exp=12345678", PrRD); end
        total++; if (PrReady !== 1'b1) begin bad++; $display("FAIL rd_ready got=%b exp=1", PrReady); end
        tick();
        total++; if (PrReady !== 1'b0) begin bad++; $display("FAIL rd_ready_pulse got=%b exp=0", PrReady); end
        total++; if (PrRD !== 32'h12345678) begin bad++; $display("FAIL rd_hold got=%h exp=12345678", PrRD); end
        // Back-to-back reads with the device word changing between them.
        DEV_RD[31:0] = 32'hAAAA0001;
        PrAddr = 32'h7F00; PrRe = 1'b1;
        tick();
        DEV_RD[31:0] = 32'hBBBB0002;
        $display("rd   addr=00007f00 data=%h ready=%b", PrRD, PrReady);
        total++; if (PrRD !== 32'hAAAA0001 || PrReady !== 1'b1)
            begin bad++; $display("FAIL b2b_first got=%h/%b exp=aaaa0001/1", PrRD, PrReady); end
        PrAddr = 32'h7F04;
        tick();
        $display("rd   addr=00007f04 data=%h ready=%b", PrRD, PrReady);
        total++; if (PrRD !== 32'hBBBB0002 || PrReady !== 1'b1)
            begin bad++; $display("FAIL b2b_second got=%h/%b exp=bbbb0002/1", PrRD, PrReady); end
        PrAddr = 32'h7F18;
        tick();
        PrRe = 1'b0;
        $display("rd   addr=00007f18 data=%h ready=%b", PrRD, PrReady);
        total++; if (PrRD !== 32'hCAFEF00D || PrReady !== 1'b1)
            begin bad++; $display("FAIL b2b_dev1 got=%h/%b exp=cafef00d/1", PrRD, PrReady); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        r;
        logic        er;
        PrAddr = 32'h7F30; PrRe = 1'b1;
        #1;
        total++; if (DEV_Re !== 2'b00) begin bad++; $display("FAIL err_re got=%b exp=00", DEV_Re); end
        tick();
        PrRe = 1'b0;
        $display("rd   addr=00007f30 data=%h ready=%b err=%b", PrRD, PrReady, PrErr);
        total++; if (PrErr !== 1'b1) begin bad++; $display("FAIL err_rd_pulse got=%b exp=1", PrErr); end
        total++; if (PrRD !== 32'h0) begin bad++; $display("FAIL err_rd_data got=%h exp=0", PrRD); end
        PrAddr = 32'h6F00; PrWD = 32'h77; PrBE = 4'hF; PrWe = 1'b1;
        #1;
        total++; if (DEV_We !== 2'b00) begin bad++; $display("FAIL err_we got=%b exp=00", DEV_We); end
        tick();
        idle();
        $display("wr   addr=00006f00 data=00000077 be=f err=%b", PrErr);
        total++; if (PrErr !== 1'b1) begin bad++; $display("FAIL err_wr_pulse got=%b exp=1", PrErr); end
        tick();
        total++; if (PrErr !== 1'b0) begin bad++; $display("FAIL err_pulse_end got=%b exp=0", PrErr); end
        do_read(32'h7F28, d, r);
        total++; if (d !== 32'h6F00) begin bad++; $display("FAIL err_addr got=%h exp=6f00", d); end
        do_read(32'h7F2C, d, r);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL err_cnt2 got=%h exp=2", d); end
        do_write(32'h7F2C, 32'h0, 4'hF, er);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL err_local_noerr got=%b exp=0", er); end
        do_read(32'h7F2C, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL err_cnt_clr got=%h exp=0", d); end
        // Just below the window base.
        do_read(32'h7EFC, d, r);
        total++; if (PrErr !== 1'b1) begin bad++; $display("FAIL err_below got=%b exp=1", PrErr); end
        do_read(32'h7F2C, d, r);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL err_cnt1 got=%h exp=1", d); end
    endtask

    task automatic test_irq_edge();
        logic [31:0] d;
        logic        r;
        logic        er;
        do_write(32'h7F20, 32'h3, 4'hF, er);
        do_read(32'h7F20, d, r);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL mask_rb got=%h exp=3", d); end
        DEV_IRQ = 2'b10;
        tick();
        DEV_IRQ = 2'b00;
        total++; if (HWInt !== 6'b000000) begin bad++; $display("FAIL edge_n1 got=%b exp=000000", HWInt); end
        tick();
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL edge_n2 got=%b exp=000010", HWInt); end
        tick();
        tick();
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL edge_held got=%b exp=000010", HWInt); end
        do_read(32'h7F24, d, r);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL pend_rb got=%h exp=2", d); end
        do_write(32'h7F24, 32'h2, 4'hF, er);
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL w1c_m1 got=%b exp=000010", HWInt); end
        tick();
        total++; if (HWInt !== 6'b000000) begin bad++; $display("FAIL w1c_m2 got=%b exp=000000", HWInt); end
        // Edge and W1C in the same cycle: the set wins.
        DEV_IRQ = 2'b10;
        do_write(32'h7F24, 32'h2, 4'hF, er);
        DEV_IRQ = 2'b00;
        tick();
        tick();
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL edge_w1c_set got=%b exp=000010", HWInt); end
    endtask

    task automatic test_irq_level();
        logic [31:0] d;
        logic        r;
        logic        er;
        DEV_IRQ = 2'b01;
        tick();
        total++; if (HWInt[0] !== 1'b0) begin bad++; $display("FAIL lvl_n1 got=%b exp=0", HWInt[0]); end
        tick();
        total++; if (HWInt[0] !== 1'b1) begin bad++; $display("FAIL lvl_n2 got=%b exp=1", HWInt[0]); end
        do_write(32'h7F24, 32'h1, 4'hF, er);
        tick();
        total++; if (HWInt[0] !== 1'b1) begin bad++; $display("FAIL lvl_w1c got=%b exp=1", HWInt[0]); end
        DEV_IRQ = 2'b00;
        tick();
        total++; if (HWInt[0] !== 1'b1) begin bad++; $display("FAIL lvl_fall1 got=%b exp=1", HWInt[0]); end
        tick();
        total++; if (HWInt[0] !== 1'b0) begin bad++; $display("FAIL lvl_fall2 got=%b exp=0", HWInt[0]); end
        DEV_IRQ = 2'b01;
        tick();
        tick();
        // Mask write on a lane other than 0 is ignored.
        do_write(32'h7F20, 32'h0, 4'h2, er);
        do_read(32'h7F20, d, r);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL mask_lane got=%h exp=3", d); end
        total++; if (HWInt !== 6'b000011) begin bad++; $display("FAIL lvl_both got=%b exp=000011", HWInt); end
        do_write(32'h7F20, 32'h0, 4'hF, er);
        total++; if (HWInt !== 6'b000011) begin bad++; $display("FAIL mask0_m1 got=%b exp=000011", HWInt); end
        tick();
        total++; if (HWInt !== 6'b000000) begin bad++; $display("FAIL mask0_m2 got=%b exp=000000", HWInt); end
        DEV_IRQ = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        r;
        logic        er;
        do_write(32'h7F20, 32'h3, 4'hF, er);
        tick();
        tick();
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL pre_rst_hw got=%b exp=000010", HWInt); end
        PrAddr = 32'h7F20; PrRe = 1'b1;
        tick();
        PrRe = 1'b0;
        total++; if (PrReady !== 1'b1 || PrRD !== 32'h3)
            begin bad++; $display("FAIL pre_rst_rd got=%h/%b exp=3/1", PrRD, PrReady); end
        #1;
        reset = 1'b1;
        #1;
        $display("rst  asserted ready=%b hwint=%b prrd=%h", PrReady, HWInt, PrRD);
        total++; if (PrReady !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0", PrReady); end
        total++; if (HWInt !== 6'h0) begin bad++; $display("FAIL rst_mid_hw got=%b exp=0", HWInt); end
        total++; if (PrRD !== 32'h0) begin bad++; $display("FAIL rst_mid_prrd got=%h exp=0", PrRD); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (PrReady !== 1'b0 || HWInt !== 6'h0)
            begin bad++; $display("FAIL rst_rel got=%b/%b exp=0/0", PrReady, HWInt); end
        do_read(32'h7F24, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_pend got=%h exp=0", d); end
        do_read(32'h7F2C, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", d); end
        do_read(32'h7F20, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mask got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_dev_write();
        test_read();
        test_errors();
        test_irq_edge();
        test_irq_level();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
